conv_window_buffer: RTL and testbench

Parametrised 2-D byte store for the convolution datapath. It is loaded one packed word at a time, per row and per word-column. It tracks fill state and serves registered ROWS x WIN sliding-window reads whose column index wraps modulo COLS. It sits between the memory-read unit and the MAC array, and replaces the fixed 4x16 combinational-output buffer.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_window_buffer_mux.sv | 29 ++
 rtl/conv_window_buffer.sv | 144 ++++++++++++++
 tb/tb_conv_window_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, defaults and index helpers for the convolution window buffer.
package conv_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam int ROW_DEF    = 4;
    localparam int COL_DEF    = 16;
    localparam int LANE_DEF   = 4;
    localparam int DATA_W_DEF = 8;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One conditional subtract; callers keep v below 2*cols.
    function automatic int wrap_col(input int v, input int cols);
        return (v >= cols) ? v - cols : v;
    endfunction

endpackage

// File: rtl/conv_window_buffer_mux.sv
// Combinational ROWS x WIN gather ending at column i_idx, wrapping mod COLS.
module window_mux import conv_pkg::*; #(
    parameter int ROWS   = 4,
    parameter int COLS   = 16,
    parameter int DATA_W = 8,
    parameter int WIN    = 4,
    parameter int CI     = 4
) (
    input  logic [DATA_W-1:0]          i_rows [ROWS][COLS],
    input  logic [CI-1:0]              i_idx,
    output logic [ROWS*WIN*DATA_W-1:0] o_window
);

    always_comb begin
        int w_base;
        logic [CI-1:0] w_col;
        o_window = '0;
        w_col    = '0;
        w_base   = wrap_col(int'(i_idx), COLS);
        for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < WIN; j++) begin
                w_col = CI'(wrap_col(w_base + COLS - (WIN - 1) + j, COLS));
                o_window[((ROWS-1-r)*WIN + (WIN-1-j))*DATA_W +: DATA_W] =
                    i_rows[r][w_col];
            end
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Row-major byte store with fill tracking and registered sliding-window reads.
module conv_window_buffer import conv_pkg::*; #(
    parameter  int ROWS   = ROW_DEF,
    parameter  int COLS   = COL_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LANES  = LANE_DEF,
    parameter  int WIN    = 4,
    localparam int RW     = safe_clog2(ROWS),
    localparam int CI     = safe_clog2(COLS),
    localparam int WPR    = COLS / LANES,
    localparam int WW     = safe_clog2(WPR),
    localparam int NWORDS = ROWS * WPR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [RW-1:0]              wr_row,
    input  logic [WW-1:0]              wr_col,
    input  logic [LANES*DATA_W-1:0]    wr_data,
    input  logic                       rd_req,
    input  logic [CI-1:0]              rd_idx,
    output logic                       rd_ready,
    output logic                       rd_valid,
    output logic [ROWS*WIN*DATA_W-1:0] rd_data,
    output logic                       full,
    output logic                       rd_err
);

    logic [DATA_W-1:0]          r_mem [ROWS][COLS];
    logic [NWORDS-1:0]          r_bitmap;
    logic [NWORDS-1:0]          w_bitmap_next;
    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_wr_ok;
    logic                       w_all_set;
    logic                       w_rd_fire;
    logic [ROWS*WIN*DATA_W-1:0] w_window;
    logic [ROWS*WIN*DATA_W-1:0] r_rd_data;
    logic                       r_rd_valid;
    logic                       r_rd_err;

    // Rows and word-columns past the array are dropped, as is anything under clear.
    assign w_wr_ok = wr_en && !clear
                   && (int'(wr_row) < ROWS)
                   && (int'(wr_col) < WPR);

    assign w_rd_fire = rd_req && (r_state == FULL);

    always_comb begin
        w_bitmap_next = clear ? '0 : r_bitmap;
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < WPR; w++) begin
                if (w_wr_ok && wr_row == RW'(r) && wr_col == WW'(w))
                    w_bitmap_next[r*WPR + w] = 1'b1;
            end
        end
    end

    assign w_all_set = &w_bitmap_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_bitmap <= '0;
        end else begin
            r_state  <= w_state_next;
            r_bitmap <= w_bitmap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = EMPTY;
        end else begin
            unique case (1'b1)
                (r_state == EMPTY): begin
                    if (w_wr_ok)
                        w_state_next = w_all_set ? FULL : FILLING;
                end
                (r_state == FILLING): begin
                    if (w_all_set)
                        w_state_next = FULL;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        rd_ready = (r_state == FULL);
        full     = (r_state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_mem[r][c] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int w = 0; w < WPR; w++) begin
                    if (w_wr_ok && wr_row == RW'(r) && wr_col == WW'(w)) begin
                        for (int k = 0; k < LANES; k++)
                            r_mem[r][w*LANES + k] <=
                                wr_data[(LANES-1-k)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    window_mux #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .WIN    (WIN),
        .CI     (CI)
    ) u_mux (
        .i_rows   (r_mem),
        .i_idx    (rd_idx),
        .o_window (w_window)
    );

    // Window is sampled from pre-write contents, so same-cycle writes read old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_err   <= rd_req && (r_state != FULL);
            if (w_rd_fire)
                r_rd_data <= w_window;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomised checks of conv_window_buffer against a byte-array window model.
module tb_conv_window_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Default configuration: 4 rows, 16 cols, 4 lanes, window 4.
    logic         a_clear, a_wr_en, a_rd_req;
    logic [1:0]   a_wr_row, a_wr_col;
    logic [31:0]  a_wr_data;
    logic [3:0]   a_rd_idx;
    logic         a_rd_ready, a_rd_valid, a_full, a_rd_err;
    logic [127:0] a_rd_data;

    // Odd configuration: 3 rows, 12 cols, 4 lanes, window 3.
    logic         b_clear, b_wr_en, b_rd_req;
    logic [1:0]   b_wr_row, b_wr_col;
    logic [31:0]  b_wr_data;
    logic [3:0]   b_rd_idx;
    logic         b_rd_ready, b_rd_valid, b_full, b_rd_err;
    logic [71:0]  b_rd_data;

    logic [7:0] ma [4][16];
    logic [7:0] mb [3][12];

    conv_window_buffer dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .wr_en(a_wr_en),
        .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_data(a_wr_data),
        .rd_req(a_rd_req), .rd_idx(a_rd_idx), .rd_ready(a_rd_ready),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .full(a_full),
        .rd_err(a_rd_err)
    );

    conv_window_buffer #(
        .ROWS(3), .COLS(12), .DATA_W(8), .LANES(4), .WIN(3)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .wr_en(b_wr_en),
        .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_data(b_wr_data),
        .rd_req(b_rd_req), .rd_idx(b_rd_idx), .rd_ready(b_rd_ready),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .full(b_full),
        .rd_err(b_rd_err)
    );

    // Window = rows top to bottom, columns oldest to newest, appended MSB-first.
    function automatic logic [127:0] exp_a(input int idx);
        logic [127:0] v;
        int c;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                c = ((idx % 16) - 3 + j + 16) % 16;
                v = {v[119:0], ma[r][c]};
            end
        return v;
    endfunction

    function automatic logic [71:0] exp_b(input int idx);
        logic [71:0] v;
        int c;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) begin
                c = ((idx % 12) - 2 + j + 12) % 12;
                v = {v[63:0], mb[r][c]};
            end
        return v;
    endfunction

    function automatic logic [31:0] word_a(input int r, input int w);
        return {ma[r][w*4], ma[r][w*4+1], ma[r][w*4+2], ma[r][w*4+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input int r, input int w, input logic [31:0] d);
        a_wr_en = 1'b1; a_wr_row = 2'(r); a_wr_col = 2'(w); a_wr_data = d;
        tick();
        a_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) ma[r][w*4+k] = d[(3-k)*8 +: 8];
    endtask

    task automatic write_b(input int r, input int w, input logic [31:0] d);
        b_wr_en = 1'b1; b_wr_row = 2'(r); b_wr_col = 2'(w); b_wr_data = d;
        tick();
        b_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) mb[r][w*4+k] = d[(3-k)*8 +: 8];
    endtask

    task automatic test_reset();
        vectors++;
        if (a_rd_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_rd_valid got %b want 0", a_rd_valid); end
        vectors++;
        if (a_rd_err !== 1'b0) begin miscompares++;
            $display("FAIL reset_rd_err got %b want 0", a_rd_err); end
        vectors++;
        if (a_rd_data !== 128'h0) begin miscompares++;
            $display("FAIL reset_rd_data got %h want 0", a_rd_data); end
        vectors++;
        if ({a_full, a_rd_ready} !== 2'b00) begin miscompares++;
            $display("FAIL reset_full_ready got %b want 00", {a_full, a_rd_ready}); end
        vectors++;
        if ({b_full, b_rd_valid, b_rd_data} !== 74'h0) begin miscompares++;
            $display("FAIL reset_b_outputs got %h want 0", {b_full, b_rd_valid, b_rd_data}); end
    endtask

    task automatic test_fill_and_early_read();
        for (int i = 0; i < 15; i++) write_a(i / 4, i % 4, $urandom);
        vectors++;
        if (a_full !== 1'b0) begin miscompares++;
            $display("FAIL fill15_full got %b want 0", a_full); end
        a_rd_req = 1'b1; a_rd_idx = 4'd7;
        tick();
        a_rd_req = 1'b0;
        vectors++;
        if ({a_rd_err, a_rd_valid} !== 2'b10) begin miscompares++;
            $display("FAIL early_read_err_valid got %b want 10", {a_rd_err, a_rd_valid}); end
        vectors++;
        if (a_rd_data !== 128'h0) begin miscompares++;
            $display("FAIL early_read_data got %h want 0", a_rd_data); end
        tick();
        vectors++;
        if (a_rd_err !== 1'b0) begin miscompares++;
            $display("FAIL early_read_err_pulse got %b want 0", a_rd_err); end
        write_a(3, 3, $urandom);
        vectors++;
        if ({a_full, a_rd_ready} !== 2'b11) begin miscompares++;
            $display("FAIL fill16_full_ready got %b want 11", {a_full, a_rd_ready}); end
    endtask

    task automatic test_window_reads();
        int idx;
        int fixed_idx [5] = '{7, 1, 0, 15, 3};
        logic [127:0] exp;
        exp = '0;
        for (int n = 0; n < 25; n++) begin
            idx = (n < 5) ? fixed_idx[n] : int'($urandom_range(15));
            exp = exp_a(idx);
            a_rd_req = 1'b1; a_rd_idx = 4'(idx);
            tick();
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin miscompares++;
                $display("FAIL window_idx%0d got v=%b %h want v=1 %h",
                         idx, a_rd_valid, a_rd_data, exp); end
        end
        a_rd_req = 1'b0;
        tick();
        vectors++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== exp) begin miscompares++;
            $display("FAIL window_hold got v=%b %h want v=0 %h", a_rd_valid, a_rd_data, exp); end
    endtask

    task automatic test_same_cycle_rw();
        logic [127:0] exp;
        exp = exp_a(7);
        a_rd_req = 1'b1; a_rd_idx = 4'd7;
        a_wr_en = 1'b1; a_wr_row = 2'd2; a_wr_col = 2'd1; a_wr_data = 32'hAABBCCDD;
        tick();
        a_wr_en = 1'b0;
        vectors++;
        if (a_rd_data !== exp) begin miscompares++;
            $display("FAIL rw_same_cycle_old got %h want %h", a_rd_data, exp); end
        ma[2][4] = 8'hAA; ma[2][5] = 8'hBB; ma[2][6] = 8'hCC; ma[2][7] = 8'hDD;
        tick();
        a_rd_req = 1'b0;
        vectors++;
        if (a_rd_data !== exp_a(7)) begin miscompares++;
            $display("FAIL rw_after_write got %h want %h", a_rd_data, exp_a(7)); end
        vectors++;
        if (a_rd_data[63:32] !== 32'hAABBCCDD) begin miscompares++;
            $display("FAIL rw_row2_bytes got %h want aabbccdd", a_rd_data[63:32]); end
    endtask

    task automatic test_random_traffic();
        logic         do_rd;
        logic [127:0] exp;
        logic [31:0]  d;
        int r, w, idx;
        for (int n = 0; n < 40; n++) begin
            do_rd = 1'($urandom_range(1));
            idx = int'($urandom_range(15));
            r = int'($urandom_range(3)); w = int'($urandom_range(3)); d = $urandom;
            exp = exp_a(idx);
            a_rd_req = do_rd; a_rd_idx = 4'(idx);
            a_wr_en = 1'($urandom_range(1)); a_wr_row = 2'(r); a_wr_col = 2'(w); a_wr_data = d;
            tick();
            if (a_wr_en)
                for (int k = 0; k < 4; k++) ma[r][w*4+k] = d[(3-k)*8 +: 8];
            a_wr_en = 1'b0;
            vectors++;
            if (a_rd_valid !== do_rd || (do_rd && a_rd_data !== exp) || a_full !== 1'b1) begin
                miscompares++;
                $display("FAIL traffic_%0d got v=%b f=%b %h want v=%b f=1 %h",
                         n, a_rd_valid, a_full, a_rd_data, do_rd, exp);
            end
        end
        a_rd_req = 1'b0;
    endtask

    task automatic test_clear();
        logic [127:0] exp;
        a_clear = 1'b1; a_wr_en = 1'b1; a_wr_row = 2'd0; a_wr_col = 2'd0;
        a_wr_data = ~word_a(0, 0);
        tick();
        a_clear = 1'b0; a_wr_en = 1'b0;
        vectors++;
        if ({a_full, a_rd_ready} !== 2'b00) begin miscompares++;
            $display("FAIL clear_full_ready got %b want 00", {a_full, a_rd_ready}); end
        a_rd_req = 1'b1; a_rd_idx = 4'd3;
        tick();
        a_rd_req = 1'b0;
        vectors++;
        if ({a_rd_err, a_rd_valid} !== 2'b10) begin miscompares++;
            $display("FAIL clear_read_err got %b want 10", {a_rd_err, a_rd_valid}); end
        for (int i = 0; i < 16; i++) write_a(i / 4, i % 4, word_a(i / 4, i % 4));
        vectors++;
        if (a_full !== 1'b1) begin miscompares++;
            $display("FAIL refill_full got %b want 1", a_full); end
        a_rd_req = 1'b1; a_rd_idx = 4'd3;
        tick();
        vectors++;
        if (a_rd_data !== exp_a(3)) begin miscompares++;
            $display("FAIL clear_discarded_write got %h want %h", a_rd_data, exp_a(3)); end
        exp = exp_a(10);
        a_rd_idx = 4'd10; a_clear = 1'b1;
        tick();
        a_clear = 1'b0; a_rd_req = 1'b0;
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== exp || a_full !== 1'b0) begin miscompares++;
            $display("FAIL read_with_clear got v=%b f=%b %h want v=1 f=0 %h",
                     a_rd_valid, a_full, a_rd_data, exp); end
    endtask

    task automatic test_rst_mid_read();
        for (int i = 0; i < 16; i++) write_a(i / 4, i % 4, $urandom);
        a_rd_req = 1'b1; a_rd_idx = 4'd5;
        #2 rst = 1'b1;
        tick();
        vectors++;
        if ({a_rd_valid, a_rd_err, a_full, a_rd_ready} !== 4'b0000 || a_rd_data !== 128'h0) begin
            miscompares++;
            $display("FAIL rst_mid_read got flags=%b %h want 0000 0",
                     {a_rd_valid, a_rd_err, a_full, a_rd_ready}, a_rd_data);
        end
        a_rd_req = 1'b0;
        rst = 1'b0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) ma[r][c] = 8'h00;
        tick();
    endtask

    task automatic test_odd_params();
        int idx;
        for (int i = 0; i < 8; i++) write_b(i / 3, i % 3, $urandom);
        vectors++;
        if (b_full !== 1'b0) begin miscompares++;
            $display("FAIL b_fill8_full got %b want 0", b_full); end
        write_b(2, 2, $urandom);
        vectors++;
        if ({b_full, b_rd_ready} !== 2'b11) begin miscompares++;
            $display("FAIL b_fill9_full got %b want 11", {b_full, b_rd_ready}); end
        b_wr_en = 1'b1; b_wr_row = 2'd3; b_wr_col = 2'd0; b_wr_data = $urandom;
        tick();
        b_wr_en = 1'b0;
        b_rd_req = 1'b1; b_rd_idx = 4'd0;
        tick();
        vectors++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== exp_b(0)) begin miscompares++;
            $display("FAIL b_wrap_idx0 got v=%b %h want v=1 %h", b_rd_valid, b_rd_data, exp_b(0)); end
        vectors++;
        if (b_rd_data[71:48] !== {mb[0][10], mb[0][11], mb[0][0]}) begin miscompares++;
            $display("FAIL b_row0_cols got %h want %h", b_rd_data[71:48],
                     {mb[0][10], mb[0][11], mb[0][0]}); end
        for (int n = 0; n < 12; n++) begin
            idx = (n < 4) ? 12 + n : int'($urandom_range(15));
            b_rd_idx = 4'(idx);
            tick();
            vectors++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== exp_b(idx)) begin miscompares++;
                $display("FAIL b_window_idx%0d got v=%b %h want v=1 %h",
                         idx, b_rd_valid, b_rd_data, exp_b(idx)); end
        end
        b_rd_req = 1'b0;
    endtask

    initial begin
        a_clear = 0; a_wr_en = 0; a_rd_req = 0; a_wr_row = 0; a_wr_col = 0;
        a_wr_data = 0; a_rd_idx = 0;
        b_clear = 0; b_wr_en = 0; b_rd_req = 0; b_wr_row = 0; b_wr_col = 0;
        b_wr_data = 0; b_rd_idx = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) ma[r][c] = 8'h00;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 12; c++) mb[r][c] = 8'h00;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_fill_and_early_read();
        test_window_reads();
        test_same_cycle_rw();
        test_random_traffic();
        test_clear();
        test_rst_mid_read();
        test_odd_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
